// File: rtl/instr_class_profiler.sv
// Instruction-mix profiler: NUM_CH programmable mask/match channels with
// saturate/wrap counters, sticky overflow, atomic snapshot and registered read port.
module instr_class_profiler #(
  parameter int unsigned NUM_CH = 11,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [31:0]       instruction,
  input  logic              instruction_issued,
  input  logic              sat_mode,
  input  logic              clear,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_ch,
  input  logic [1:0]        cfg_field,
  input  logic [31:0]       cfg_wdata,
  input  logic              snap_req,
  output logic              snap_done,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_ch,
  input  logic              rd_shadow,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] overflow
);

  localparam logic [1:0] FIELD_MASK  = 2'b00;
  localparam logic [1:0] FIELD_MATCH = 2'b01;
  localparam logic [1:0] FIELD_EN    = 2'b10;

  logic [31:0]       mask_q   [NUM_CH];
  logic [31:0]       mask_d   [NUM_CH];
  logic [31:0]       match_q  [NUM_CH];
  logic [31:0]       match_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [NUM_CH-1:0] overflow_q, overflow_d;
  logic [NUM_CH-1:0] hit_c;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              snap_done_q, snap_done_d;
  logic              cfg_ok_c;

  // Hit decode always uses the configuration registered before this edge
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hit_c[i] = instruction_issued & enable & ch_en_q[i] &
                 ((instruction & mask_q[i]) == match_q[i]);
    end
  end

  assign cfg_ok_c = cfg_we && (32'(cfg_ch) < NUM_CH);

  // Configuration, counter, snapshot and read next-state
  always_comb begin
    ch_en_d     = ch_en_q;
    overflow_d  = overflow_q;
    rd_valid_d  = rd_en;
    rd_data_d   = rd_data_q;
    snap_done_d = snap_req;
    for (int i = 0; i < NUM_CH; i++) begin
      mask_d[i]   = mask_q[i];
      match_d[i]  = match_q[i];
      cnt_d[i]    = cnt_q[i];
      shadow_d[i] = shadow_q[i];

      if (cfg_ok_c && (cfg_ch == IDX_W'(i))) begin
        case (cfg_field)
          FIELD_MASK:  mask_d[i]  = cfg_wdata;
          FIELD_MATCH: match_d[i] = cfg_wdata;
          FIELD_EN:    ch_en_d[i] = cfg_wdata[0];
          default:     ;
        endcase
      end

      if (clear) begin
        cnt_d[i]      = '0;
        overflow_d[i] = 1'b0;
      end else if (hit_c[i]) begin
        if (&cnt_q[i]) begin
          overflow_d[i] = 1'b1;
          if (!sat_mode) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      if (snap_req) shadow_d[i] = cnt_q[i];
    end

    // Out-of-range channel reads return zero
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_ch == IDX_W'(i)) rd_data_d = rd_shadow ? shadow_q[i] : cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mask_q[i]   <= '0;
        match_q[i]  <= '0;
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ch_en_q     <= '0;
      overflow_q  <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      snap_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        mask_q[i]   <= mask_d[i];
        match_q[i]  <= match_d[i];
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ch_en_q     <= ch_en_d;
      overflow_q  <= overflow_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      snap_done_q <= snap_done_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign snap_done = snap_done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_instr_class_profiler.sv
// Randomised bench for instr_class_profiler: cycle-by-cycle comparison against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_instr_class_profiler;

  localparam int unsigned NUM_CH = 11;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned MAXV   = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [31:0]       instruction;
  logic              instruction_issued;
  logic              sat_mode;
  logic              clear;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_ch;
  logic [1:0]        cfg_field;
  logic [31:0]       cfg_wdata;
  logic              snap_req;
  logic              snap_done;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_ch;
  logic              rd_shadow;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] overflow;

  int vectors = 0;
  int miscompares = 0;

  instr_class_profiler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .instruction(instruction),
    .instruction_issued(instruction_issued), .sat_mode(sat_mode), .clear(clear),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .snap_req(snap_req), .snap_done(snap_done), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_shadow(rd_shadow), .rd_data(rd_data), .rd_valid(rd_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0]  m_mask  [NUM_CH];
  logic [31:0]  m_match [NUM_CH];
  bit           m_en    [NUM_CH];
  int unsigned  m_cnt   [NUM_CH];
  int unsigned  m_sh    [NUM_CH];
  bit           m_ovf   [NUM_CH];
  int unsigned  m_rd_data;
  bit           m_rd_valid;
  bit           m_snap_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] model_ovf();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_mask[i] = '0; m_match[i] = '0; m_en[i] = 0;
        m_cnt[i] = 0; m_sh[i] = 0; m_ovf[i] = 0;
      end
      m_rd_data = 0; m_rd_valid = 0; m_snap_done = 0;
    end else begin
      bit hit [NUM_CH];
      for (int i = 0; i < NUM_CH; i++)
        hit[i] = instruction_issued && enable && m_en[i] &&
                 ((instruction & m_mask[i]) == m_match[i]);
      m_rd_valid = rd_en;
      if (rd_en) begin
        if (int'(rd_ch) < NUM_CH) m_rd_data = rd_shadow ? m_sh[rd_ch] : m_cnt[rd_ch];
        else m_rd_data = 0;
      end
      m_snap_done = snap_req;
      for (int i = 0; i < NUM_CH; i++) begin
        if (snap_req) m_sh[i] = m_cnt[i];
        if (clear) begin
          m_cnt[i] = 0; m_ovf[i] = 0;
        end else if (hit[i]) begin
          if (m_cnt[i] + 1 > MAXV) begin
            m_ovf[i] = 1;
            m_cnt[i] = sat_mode ? MAXV : 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (cfg_we && int'(cfg_ch) < NUM_CH) begin
        case (cfg_field)
          2'd0: m_mask[cfg_ch]  = cfg_wdata;
          2'd1: m_match[cfg_ch] = cfg_wdata;
          2'd2: m_en[cfg_ch]    = cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    check("snap_done", 64'(snap_done), 64'(m_snap_done));
    check("overflow", 64'(overflow), 64'(model_ovf()));
    check("rd_data", 64'(rd_data), 64'(m_rd_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input logic [1:0] field, input logic [31:0] data);
    cfg_we = 1'b1; cfg_ch = IDX_W'(ch); cfg_field = field; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] keep_mask, input logic [31:0] opc, input int n);
    for (int k = 0; k < n; k++) begin
      instruction_issued = 1'b1;
      instruction = ($urandom() & ~keep_mask) | opc;
      tick();
    end
    instruction_issued = 1'b0;
  endtask

  task automatic read_lit(input string name, input int ch, input bit sh, input int unsigned exp);
    rd_en = 1'b1; rd_ch = IDX_W'(ch); rd_shadow = sh;
    tick();
    rd_en = 1'b0;
    check({name, "_valid"}, 64'(rd_valid), 64'd1);
    check(name, 64'(rd_data), 64'(exp));
  endtask

  function automatic logic [31:0] pick_mask();
    case ($urandom_range(0, 3))
      0: return 32'h0000_007F;
      1: return 32'h0000_707F;
      2: return 32'h0000_0000;
      default: return 32'h0000_0003;
    endcase
  endfunction

  function automatic logic [31:0] pick_opc();
    case ($urandom_range(0, 3))
      0: return 32'h03;
      1: return 32'h13;
      2: return 32'h23;
      default: return 32'h33;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; enable = 1'b0; instruction = '0; instruction_issued = 1'b0;
    sat_mode = 1'b0; clear = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_field = '0;
    cfg_wdata = '0; snap_req = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_shadow = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);

    // Loads on ch0; stores must not count; disabled channels stay 0
    enable = 1'b1;
    cfg(0, 2'd0, 32'h7F); cfg(0, 2'd1, 32'h03); cfg(0, 2'd2, 32'h1);
    issue(32'h7F, 32'h03, 5);
    issue(32'h7F, 32'h23, 3);
    read_lit("ch0_loads", 0, 1'b0, 5);
    read_lit("ch3_disabled", 3, 1'b0, 0);

    // Multi-channel hit: ADDI counts in ch1 and ch2
    cfg(1, 2'd0, 32'h0000_707F); cfg(1, 2'd1, 32'h13); cfg(1, 2'd2, 32'h1);
    cfg(2, 2'd0, 32'h7F);        cfg(2, 2'd1, 32'h13); cfg(2, 2'd2, 32'h1);
    issue(32'h0000_707F, 32'h13, 4);
    read_lit("ch1_addi", 1, 1'b0, 4);
    read_lit("ch2_opimm", 2, 1'b0, 4);
    read_lit("ch0_unchanged", 0, 1'b0, 5);
    read_lit("rd_out_of_range", 13, 1'b0, 0);

    // Saturate then wrap over 260 hits
    clear = 1'b1; tick(); clear = 1'b0;
    sat_mode = 1'b1;
    issue(32'h7F, 32'h03, 260);
    read_lit("sat_live", 0, 1'b0, 255);
    check("sat_ovf", 64'(overflow[0]), 64'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_ovf", 64'(overflow[0]), 64'd0);
    sat_mode = 1'b0;
    issue(32'h7F, 32'h03, 260);
    read_lit("wrap_live", 0, 1'b0, 4);
    check("wrap_ovf", 64'(overflow[0]), 64'd1);

    // Atomic snapshot-and-clear with a hitting instruction in the same cycle
    clear = 1'b1; tick(); clear = 1'b0;
    issue(32'h7F, 32'h03, 10);
    snap_req = 1'b1; clear = 1'b1; instruction_issued = 1'b1; instruction = 32'h0000_2003;
    tick();
    snap_req = 1'b0; clear = 1'b0; instruction_issued = 1'b0;
    check("snap_done_pulse", 64'(snap_done), 64'd1);
    tick();
    check("snap_done_clears", 64'(snap_done), 64'd0);
    read_lit("shadow_ch0", 0, 1'b1, 10);
    read_lit("live_after_snapclr", 0, 1'b0, 0);

    // Config write in the hit cycle uses the old match
    instruction_issued = 1'b1; instruction = 32'h0000_0003;
    cfg_we = 1'b1; cfg_ch = '0; cfg_field = 2'd1; cfg_wdata = 32'h7F;
    tick();
    cfg_we = 1'b0;
    instruction = 32'h0000_0003;
    tick();
    instruction_issued = 1'b0;
    read_lit("cfg_same_cycle", 0, 1'b0, 1);

    // Hold while disabled, then reset mid-stream with pending read/snapshot
    cfg(0, 2'd1, 32'h03);
    clear = 1'b1; tick(); clear = 1'b0;
    issue(32'h7F, 32'h03, 7);
    enable = 1'b0;
    issue(32'h7F, 32'h03, 20);
    read_lit("disabled_hold", 0, 1'b0, 7);
    instruction_issued = 1'b1; instruction = 32'h03;
    rd_en = 1'b1; rd_ch = '0; snap_req = 1'b1;
    rst_n = 1'b0;
    tick();
    rd_en = 1'b0; snap_req = 1'b0; instruction_issued = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_snap_done", 64'(snap_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    enable = 1'b1;
    issue(32'h7F, 32'h03, 3);
    read_lit("rst_cfg_cleared", 0, 1'b0, 0);
    read_lit("rst_shadow", 0, 1'b1, 0);

    // Randomised phase against the model
    for (int c = 0; c < NUM_CH; c++) begin
      cfg(c, 2'd0, pick_mask()); cfg(c, 2'd1, pick_opc()); cfg(c, 2'd2, 32'h1);
    end
    for (int n = 0; n < 4000; n++) begin
      enable             = ($urandom_range(0, 7) != 0);
      instruction_issued = ($urandom_range(0, 3) != 0);
      instruction        = ($urandom() & ~32'h7F) | pick_opc();
      if ($urandom_range(0, 1) == 0) instruction[14:12] = 3'b000;
      if ($urandom_range(0, 199) == 0) sat_mode = ~sat_mode;
      clear     = ($urandom_range(0, 127) == 0);
      cfg_we    = ($urandom_range(0, 31) == 0);
      cfg_ch    = IDX_W'($urandom_range(0, 15));
      cfg_field = 2'($urandom_range(0, 3));
      cfg_wdata = (cfg_field == 2'd0) ? pick_mask() :
                  (cfg_field == 2'd1) ? pick_opc() : 32'($urandom_range(0, 7) != 0);
      snap_req  = ($urandom_range(0, 15) == 0);
      rd_en     = ($urandom_range(0, 1) == 0);
      rd_ch     = IDX_W'($urandom_range(0, 15));
      rd_shadow = 1'($urandom_range(0, 1));
      tick();
    end
    cfg_we = 1'b0; rd_en = 1'b0; snap_req = 1'b0; clear = 1'b0; instruction_issued = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
